// File: rtl/raifes_wb_unit.sv
// rtl/raifes_wb_unit.sv - writeback stage: selects ALU/CSR/PC+4 results and completes loads
// Loads park in WAIT_LOAD for the bus response; a flushed load drains its pending response.
module raifes_wb_unit (
    input  logic        clk,
    input  logic        nreset,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_wen,
    input  logic [4:0]  ex_rd,
    input  logic [1:0]  ex_wb_sel,
    input  logic [31:0] ex_alu_out,
    input  logic [31:0] ex_csr_rdata,
    input  logic [31:0] ex_pc,
    input  logic [2:0]  ex_mem_type,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_error,
    input  logic        flush,
    output logic        rf_wen,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        load_fault,
    output logic        load_misaligned,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, WAIT_LOAD, DRAIN} state_t;

    state_t      state_q;
    logic        rf_wen_q;
    logic [4:0]  rf_waddr_q;
    logic [31:0] rf_wdata_q;
    logic        load_fault_q;
    logic        load_misaligned_q;
    logic [4:0]  ld_rd_q;
    logic        ld_wen_q;
    logic [2:0]  ld_type_q;
    logic [1:0]  ld_off_q;

    logic        accept;
    logic        ex_misaligned;
    logic [31:0] ex_result;
    logic [31:0] load_data;
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    assign ex_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign accept   = ex_valid && ex_ready && !flush;

    always_comb begin
        ex_misaligned = 1'b0;
        case (ex_mem_type)
            3'd1, 3'd5: ex_misaligned = ex_alu_out[0];
            3'd2:       ex_misaligned = (ex_alu_out[1:0] != 2'd0);
            default:    ex_misaligned = 1'b0;
        endcase
    end

    always_comb begin
        ex_result = ex_alu_out;
        case (ex_wb_sel)
            2'd2:    ex_result = ex_csr_rdata;
            2'd3:    ex_result = ex_pc + 32'd4;
            default: ex_result = ex_alu_out;
        endcase
    end

    always_comb begin
        load_byte = dmem_rdata[7:0];
        case (ld_off_q)
            2'd1:    load_byte = dmem_rdata[15:8];
            2'd2:    load_byte = dmem_rdata[23:16];
            2'd3:    load_byte = dmem_rdata[31:24];
            default: load_byte = dmem_rdata[7:0];
        endcase
        load_half = ld_off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        load_data = dmem_rdata;
        case (ld_type_q)
            3'd0:    load_data = {{24{load_byte[7]}}, load_byte};
            3'd1:    load_data = {{16{load_half[15]}}, load_half};
            3'd4:    load_data = {24'd0, load_byte};
            3'd5:    load_data = {16'd0, load_half};
            default: load_data = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q           <= IDLE;
            rf_wen_q          <= 1'b0;
            rf_waddr_q        <= 5'd0;
            rf_wdata_q        <= 32'd0;
            load_fault_q      <= 1'b0;
            load_misaligned_q <= 1'b0;
            ld_rd_q           <= 5'd0;
            ld_wen_q          <= 1'b0;
            ld_type_q         <= 3'd0;
            ld_off_q          <= 2'd0;
        end else begin
            rf_wen_q          <= 1'b0;
            load_fault_q      <= 1'b0;
            load_misaligned_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (ex_wb_sel == 2'd1) begin
                            if (ex_misaligned) begin
                                load_misaligned_q <= 1'b1;
                            end else begin
                                ld_rd_q   <= ex_rd;
                                ld_wen_q  <= ex_wen && (ex_rd != 5'd0);
                                ld_type_q <= ex_mem_type;
                                ld_off_q  <= ex_alu_out[1:0];
                                state_q   <= WAIT_LOAD;
                            end
                        end else begin
                            rf_wen_q   <= ex_wen && (ex_rd != 5'd0);
                            rf_waddr_q <= ex_rd;
                            rf_wdata_q <= ex_result;
                        end
                    end
                end
                WAIT_LOAD: begin
                    // A flush racing the response wins: the response belongs to a killed instruction.
                    if (dmem_rvalid) begin
                        state_q <= IDLE;
                        if (!flush) begin
                            if (dmem_error) begin
                                load_fault_q <= 1'b1;
                            end else begin
                                rf_wen_q   <= ld_wen_q;
                                rf_waddr_q <= ld_rd_q;
                                rf_wdata_q <= load_data;
                            end
                        end
                    end else if (flush) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (dmem_rvalid) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rf_wen          = rf_wen_q;
    assign rf_waddr        = rf_waddr_q;
    assign rf_wdata        = rf_wdata_q;
    assign load_fault      = load_fault_q;
    assign load_misaligned = load_misaligned_q;

endmodule

// File: tb/tb_raifes_wb_unit.sv
// tb/tb_raifes_wb_unit.sv - directed and randomized checks of raifes_wb_unit against a reference model
module tb_raifes_wb_unit;

    logic        clk;
    logic        nreset;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_wen;
    logic [4:0]  ex_rd;
    logic [1:0]  ex_wb_sel;
    logic [31:0] ex_alu_out;
    logic [31:0] ex_csr_rdata;
    logic [31:0] ex_pc;
    logic [2:0]  ex_mem_type;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        dmem_error;
    logic        flush;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        load_fault;
    logic        load_misaligned;
    logic        busy;

    int checks = 0;
    int errors = 0;

    raifes_wb_unit dut (
        .clk(clk), .nreset(nreset),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_wen(ex_wen), .ex_rd(ex_rd),
        .ex_wb_sel(ex_wb_sel), .ex_alu_out(ex_alu_out), .ex_csr_rdata(ex_csr_rdata),
        .ex_pc(ex_pc), .ex_mem_type(ex_mem_type),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .dmem_error(dmem_error),
        .flush(flush),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .load_fault(load_fault), .load_misaligned(load_misaligned), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: a load is either outstanding, being drained, or absent.
    bit          m_pending;
    bit          m_draining;
    bit [4:0]    m_rd;
    bit          m_wen;
    bit [2:0]    m_type;
    bit [1:0]    m_off;
    bit          exp_wen, exp_fault, exp_mis, exp_rst;
    bit [4:0]    exp_waddr;
    bit [31:0]   exp_wdata;

    function automatic bit [31:0] ref_load(input bit [2:0] t, input bit [1:0] off, input bit [31:0] d);
        bit [31:0] byte_sh, half_sh;
        byte_sh = d >> (32'(off) * 8);
        half_sh = d >> (32'(off[1]) * 16);
        case (t)
            3'd0:    return 32'($signed(byte_sh[7:0]));
            3'd1:    return 32'($signed(half_sh[15:0]));
            3'd4:    return 32'(byte_sh[7:0]);
            3'd5:    return 32'(half_sh[15:0]);
            default: return d;
        endcase
    endfunction

    function automatic bit ref_misaligned(input bit [2:0] t, input bit [31:0] a);
        if (t == 3'd1 || t == 3'd5) return (a % 2) != 0;
        if (t == 3'd2)              return (a % 4) != 0;
        return 1'b0;
    endfunction

    task automatic model_step();
        exp_wen = 0; exp_fault = 0; exp_mis = 0; exp_rst = 0;
        if (!nreset) begin
            m_pending = 0; m_draining = 0;
            exp_waddr = 0; exp_wdata = 0; exp_rst = 1;
        end else if (m_pending) begin
            if (dmem_rvalid) begin
                m_pending = 0;
                if (!flush && dmem_error) exp_fault = 1;
                else if (!flush) begin
                    exp_wen   = m_wen && (m_rd != 0);
                    exp_waddr = m_rd;
                    exp_wdata = ref_load(m_type, m_off, dmem_rdata);
                end
            end else if (flush) begin
                m_pending = 0; m_draining = 1;
            end
        end else if (m_draining) begin
            if (dmem_rvalid) m_draining = 0;
        end else if (ex_valid && !flush) begin
            if (ex_wb_sel == 2'd1) begin
                if (ref_misaligned(ex_mem_type, ex_alu_out)) exp_mis = 1;
                else begin
                    m_pending = 1; m_rd = ex_rd; m_wen = ex_wen;
                    m_type = ex_mem_type; m_off = ex_alu_out[1:0];
                end
            end else begin
                exp_wen   = ex_wen && (ex_rd != 0);
                exp_waddr = ex_rd;
                exp_wdata = (ex_wb_sel == 2'd2) ? ex_csr_rdata :
                            (ex_wb_sel == 2'd3) ? ex_pc + 32'd4 : ex_alu_out;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("ex_ready", 32'(ex_ready), 32'(!(m_pending || m_draining)));
        chk("busy", 32'(busy), 32'(m_pending || m_draining));
        chk("rf_wen", 32'(rf_wen), 32'(exp_wen));
        chk("load_fault", 32'(load_fault), 32'(exp_fault));
        chk("load_misaligned", 32'(load_misaligned), 32'(exp_mis));
        if (exp_wen || exp_rst) begin
            chk("rf_waddr", 32'(rf_waddr), 32'(exp_waddr));
            chk("rf_wdata", rf_wdata, exp_wdata);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic issue(input bit [1:0] sel, input bit [4:0] rd, input bit [31:0] alu,
                         input bit [2:0] mt);
        ex_valid = 1; ex_wen = 1; ex_rd = rd; ex_wb_sel = sel; ex_alu_out = alu; ex_mem_type = mt;
        cyc();
        ex_valid = 0;
    endtask

    bit [2:0] types [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    initial begin
        nreset = 0; ex_valid = 0; ex_wen = 0; ex_rd = 0; ex_wb_sel = 0; ex_alu_out = 0;
        ex_csr_rdata = 0; ex_pc = 0; ex_mem_type = 0; dmem_rvalid = 0; dmem_rdata = 0;
        dmem_error = 0; flush = 0;
        m_pending = 0; m_draining = 0; m_rd = 0; m_wen = 0; m_type = 0; m_off = 0;
        exp_waddr = 0; exp_wdata = 0;
        #2;
        cyc(); cyc();
        chk("reset_waddr", 32'(rf_waddr), 32'd0);
        chk("reset_wdata", rf_wdata, 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        nreset = 1;

        issue(2'd0, 5'd5, 32'h1234_5678, 3'd0);
        chk("alu_wen", 32'(rf_wen), 32'd1);
        chk("alu_waddr", 32'(rf_waddr), 32'd5);
        chk("alu_wdata", rf_wdata, 32'h1234_5678);

        ex_pc = 32'hFFFF_FFFC;
        issue(2'd3, 5'd1, 32'h0, 3'd0);
        chk("pc4_wrap", rf_wdata, 32'h0000_0000);

        issue(2'd1, 5'd7, 32'h0000_1003, 3'd0);
        dmem_rvalid = 1; dmem_rdata = 32'h80AA_BBCC;
        cyc();
        dmem_rvalid = 0;
        chk("lb_wen", 32'(rf_wen), 32'd1);
        chk("lb_data", rf_wdata, 32'hFFFF_FF80);
        issue(2'd1, 5'd7, 32'h0000_1003, 3'd4);
        dmem_rvalid = 1;
        cyc();
        dmem_rvalid = 0;
        chk("lbu_data", rf_wdata, 32'h0000_0080);

        issue(2'd1, 5'd9, 32'h0000_2002, 3'd2);
        chk("lw_mis_pulse", 32'(load_misaligned), 32'd1);
        chk("lw_mis_nowen", 32'(rf_wen), 32'd0);
        chk("lw_mis_ready", 32'(ex_ready), 32'd1);
        cyc();
        chk("lw_mis_once", 32'(load_misaligned), 32'd0);

        issue(2'd1, 5'd3, 32'h0000_0000, 3'd1);
        cyc();
        flush = 1; cyc(); flush = 0;
        chk("drain_busy", 32'(busy), 32'd1);
        cyc(); cyc();
        chk("drain_ready", 32'(ex_ready), 32'd0);
        dmem_rvalid = 1; cyc(); dmem_rvalid = 0;
        chk("drain_idle", 32'(busy), 32'd0);
        chk("drain_nowen", 32'(rf_wen), 32'd0);

        issue(2'd1, 5'd4, 32'h0000_0004, 3'd2);
        dmem_rvalid = 1; dmem_error = 1; cyc(); dmem_rvalid = 0; dmem_error = 0;
        chk("fault_pulse", 32'(load_fault), 32'd1);
        chk("fault_nowen", 32'(rf_wen), 32'd0);
        cyc();
        chk("fault_once", 32'(load_fault), 32'd0);
        issue(2'd0, 5'd0, 32'hDEAD_BEEF, 3'd0);
        chk("x0_nowen", 32'(rf_wen), 32'd0);

        issue(2'd1, 5'd6, 32'h0, 3'd2);
        nreset = 0; cyc(); nreset = 1;
        dmem_rvalid = 1; cyc(); dmem_rvalid = 0;
        chk("reset_abandon", 32'(rf_wen), 32'd0);

        for (int i = 0; i < 4000; i++) begin
            nreset       = ($urandom_range(0, 99) != 0);
            ex_valid     = ($urandom_range(0, 9) < 6);
            ex_wen       = ($urandom_range(0, 9) != 0);
            ex_rd        = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            ex_wb_sel    = 2'($urandom);
            ex_alu_out   = $urandom;
            ex_csr_rdata = $urandom;
            ex_pc        = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
            ex_mem_type  = types[$urandom_range(0, 4)];
            dmem_rvalid  = ($urandom_range(0, 9) < 3);
            dmem_rdata   = $urandom;
            dmem_error   = ($urandom_range(0, 7) == 0);
            flush        = ($urandom_range(0, 9) == 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/raifes_wb_unit.md
RAIFES_WB_UNIT -- requirements
Module: raifes_wb_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk  in  1  rising-edge clock; nreset  in  1  synchronous active-low reset.
REQ-002 The block SHALL have these ports:
- ex_valid  in  1  execute stage presents a result or load
- ex_ready  out  1  unit accepts the ex_* bundle this cycle
- ex_wen  in  1  instruction writes rd
- ex_rd  in  5  destination register
- ex_wb_sel  in  2  source select: 0 = ALU, 1 = LOAD, 2 = CSR, 3 = PC+4
- ex_alu_out  in  32  ALU result; also the load address
- ex_csr_rdata  in  32  CSR read data
- ex_pc  in  32  PC of the instruction
- ex_mem_type  in  3  funct3: 0 = LB, 1 = LH, 2 = LW, 4 = LBU, 5 = LHU
- dmem_rvalid  in  1  load response valid, single-cycle pulse
- dmem_rdata  in  32  aligned load word
- dmem_error  in  1  bus error, qualified by dmem_rvalid
- flush  in  1  kill the in-flight instruction
- rf_wen  out  1  register-file write strobe
- rf_waddr  out  5  write address
- rf_wdata  out  32  write data
- load_fault  out  1  one-cycle pulse: bus error
- load_misaligned  out  1  one-cycle pulse: misaligned load
- busy  out  1  high whenever state is not IDLE

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, WAIT_LOAD and DRAIN.
REQ-004 ex_ready SHALL be 1 in IDLE and 0 in WAIT_LOAD and DRAIN, combinationally from state.
REQ-005 Accept SHALL occur when ex_valid && ex_ready && !flush; with flush high, the bundle is discarded and there is no side effect.
REQ-006 An accept with ex_wb_sel of 0, 2 or 3 SHALL register the selected value on the next edge, with rf_wen = ex_wen && (ex_rd != 0); the PC+4 value is ex_pc + 4, modulo 2^32.
REQ-007 An accept with ex_wb_sel = 1 SHALL record rd, ex_wen, ex_mem_type and ex_alu_out[1:0], then enter WAIT_LOAD.
REQ-008 A misaligned load SHALL be LH/LHU with addr[0] = 1, or LW with addr[1:0] != 0.
REQ-009 A misaligned load SHALL pulse load_misaligned on the next cycle, SHALL NOT write, and SHALL stay in IDLE.
REQ-010 In WAIT_LOAD, dmem_rvalid && !dmem_error SHALL extract the data and register it with rf_wen on the next edge, then return to IDLE.
- Byte: dmem_rdata[8*addr+7 : 8*addr].
- Half: dmem_rdata[16*addr[1]+15 : 16*addr[1]].
- LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
REQ-011 In WAIT_LOAD, dmem_rvalid && dmem_error SHALL pulse load_fault on the next cycle with no write, then return to IDLE.
REQ-012 flush in WAIT_LOAD without dmem_rvalid SHALL move the FSM to DRAIN; flush coincident with dmem_rvalid SHALL discard the response and return to IDLE, with no write and no fault.
REQ-013 In DRAIN, the next dmem_rvalid SHALL be discarded, regardless of dmem_error, and the FSM SHALL return to IDLE.
REQ-014 rf_wen, load_fault and load_misaligned SHALL each be high for exactly one cycle per event, and rf_waddr/rf_wdata SHALL be valid while rf_wen is high.
REQ-015 Writes to x0 SHALL never assert rf_wen.
REQ-016 Back-to-back accepts of non-load results SHALL produce rf_wen on consecutive cycles, for a throughput of 1 per cycle.
REQ-017 A load SHALL have a minimum latency of 2 cycles, from the accept edge to rf_wen, when dmem_rvalid arrives in the cycle after accept.
REQ-018 dmem_rvalid SHALL be ignored in IDLE.

Reset
REQ-019 While nreset = 0 at a clk edge, the block SHALL reset to:
- state = IDLE
- rf_wen = 0, rf_waddr = 0, rf_wdata = 0
- load_fault = 0, load_misaligned = 0
- busy = 0
REQ-020 Reset mid-load SHALL abandon the load, and any later dmem_rvalid SHALL be ignored per REQ-018.

Verification
REQ-021 ALU accept, rd = 5, ex_alu_out = 0x1234_5678 -> next cycle rf_wen = 1, rf_waddr = 5, rf_wdata = 0x1234_5678.
REQ-022 PC+4 with ex_pc = 0xFFFF_FFFC, rd = 1 -> rf_wdata = 0x0000_0000 (wrap-around).
REQ-023 LB, addr = 0x...3, dmem_rdata = 0x80AA_BBCC one cycle later -> rf_wdata = 0xFFFF_FF80; LBU on the same data -> 0x0000_0080.
REQ-024 LW, addr = 0x...2 -> load_misaligned pulses once, rf_wen stays 0, ex_ready remains 1.
REQ-025 LH accepted, flush 2 cycles later, then dmem_rvalid 3 cycles after that -> busy through DRAIN, no rf_wen, returns to IDLE the cycle after rvalid.
REQ-026 LW accepted, dmem_rvalid with dmem_error = 1 -> load_fault pulses once, no write; a separate ALU write to rd = 0 -> rf_wen stays 0.
